bit_field_extractor: RTL and testbench
======================================

Name: bit_field_extractor

Overview:
- Streaming bit unpacker. Accepts fixed WIDTH-bit words and emits variable-length fields of 1..WIDTH bits, LSB-first.
- Holds a 2*WIDTH-bit residue buffer and a bit count. Alignment uses a shared-package barrel shift stage, left and right.
- Sits upstream of decode logic, e.g. an instruction-field or bitstream parser, and downstream of a word-wide memory or FIFO.

Parameters:
- WIDTH, 64, word width and maximum field length in bits; power of 2, ≥ 4.
- SHIFT_WIDTH, CLOG2(WIDTH), width of the field-length port.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- flush  input  1  synchronous discard of all buffered bits.
- in_data  input  WIDTH  input word; bit 0 is consumed first.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept a word this cycle.
- fld_len  input  SHIFT_WIDTH  requested field length; 0 encodes WIDTH.
- fld_ready  input  1  consumer takes the field this cycle.
- fld_valid  output  1  buffer holds ≥ requested length bits.
- fld_data  output  WIDTH  extracted field; bits above length are zero.
- level  output  SHIFT_WIDTH+2  current buffered bit count, 0..2*WIDTH.

Behaviour:
- State: buf[2W-1:0] and cnt. Valid bits are always buf[cnt-1:0]; bits above cnt are always zero.
- Reset (async assert, sync-free deassert): buf=0, cnt=0. Resulting outputs: level=0, in_ready=1, fld_valid=0, fld_data=0.
- L = (fld_len==0) ? WIDTH : fld_len.
- in_ready = (cnt <= WIDTH). Registered-state only; no combinational path from fld_* to in_ready.
- fld_valid = (cnt >= L). This is combinational from fld_len; the consumer must hold fld_len stable while fld_ready is low.
- fld_data = buf[L-1:0] zero-extended. Combinational from registers and fld_len.
- take = fld_valid & fld_ready; push = in_valid & in_ready.
- Next state:
  - take only: buf = buf >> L; cnt -= L.
  - push only: buf |= in_data << cnt; cnt += WIDTH.
  - both: buf = (buf >> L) | (in_data << (cnt-L)); cnt = cnt - L + WIDTH.
  - neither: hold.
- Latency: a word accepted in cycle N is extractable from cycle N+1. No same-cycle bypass: when cnt=0, fld_valid=0 even if in_valid=1.
- Throughput: one word in and one field out per cycle, sustained.
- Full boundary: cnt=2W requires W < cnt, so in_ready=0. cnt=WIDTH still accepts, giving cnt=2W.
- Empty boundary: cnt < L holds fld_valid=0. Partial bits are retained, never dropped.
- flush: next buf=0, cnt=0. It overrides a simultaneous push and take; both handshakes are ignored that cycle.
- Reset mid-operation discards all buffered bits immediately.
- Shifts: right shift by L and left shift by cnt or cnt-L are 2W-wide logical shifts with zero fill. The shift amount for push is < 2W, guaranteed by in_ready.

Optional Feature:
- Macro: BIT_FIELD_EXTRACTOR_SIGN_EXT_EN.
- Defined: adds input port fld_signed (1 bit). When set, fld_data[WIDTH-1:L] replicate fld_data[L-1]; when clear, they are zero.
- Undefined: no port; fld_data is always zero-extended.
- Buffer and count behaviour are identical in both builds.

Decomposition:
- Shared package bfx_pkg holds:
  - typedef for the cnt/level type (SHIFT_WIDTH+2 bits);
  - localparam BUF_WIDTH = 2*WIDTH;
  - function len_decode(fld_len) returning L.
- One natural sub-module: logic_shifter_2w.
  - Parameterized zero-fill logical shifter, direction input.
  - Stage-per-shift-bit mux structure.
  - Instantiated twice: one right-shift path, one left-shift path.
- Mask and sign-extension generation stays in the top module.

Test Plan (WIDTH=8 unless stated):
- Reset, then push words 0xA5 and 0x3C; request lengths 3,5,4,4 with fld_ready=1 → fields 0x05, 0x14, 0x0C, 0x03; level ends at 0.
- Fill without consuming → in_ready drops after the 2nd word (level=16); a 3rd in_valid is not accepted; take L=8 → in_ready=1 next cycle.
- Hold level=4 and request fld_len=5 → fld_valid=0. Push 0xFF in the same cycle → fld_valid=1 next cycle with 5 correct bits.
- Simultaneous push+take at level=6, L=6 → level=8 next cycle and buf equals the new word.
- fld_len=0 with level=8 → fld_valid=1, field is the full 8 bits.
- Assert flush with level=11 while in_valid=1 → level=0 and no word absorbed. Assert rst mid-stream → outputs return to reset values immediately.
- SIGN_EXT_EN build: field 0b101, L=3, fld_signed=1 → 0xFD; with fld_signed=0 → 0x05.

Source files
------------

// File: rtl/bit_field_extractor_pkg.sv
// Shared types, constants and helpers for the bit_field_extractor streaming unpacker.
// Optional build macro used by the top: BIT_FIELD_EXTRACTOR_SIGN_EXT_EN.
package bfx_pkg;

   localparam int DEF_WIDTH       = 64;
   localparam int DEF_SHIFT_WIDTH = $clog2(DEF_WIDTH);
   localparam int BUF_WIDTH       = 2 * DEF_WIDTH;

   typedef logic [DEF_SHIFT_WIDTH+1:0] level_t;

   // A zero length field request stands for a full word.
   function automatic int unsigned len_decode(input int unsigned fld_len, input int unsigned width);
      return (fld_len == 0) ? width : fld_len;
   endfunction

endpackage

// File: rtl/bit_field_extractor_if.sv
// Word-in / field-out handshake bundle of the bit_field_extractor.
// master = word producer plus field consumer, slave = the extractor itself.
interface bit_field_extractor_if
   import bfx_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int SHIFT_WIDTH = $clog2(WIDTH)
);

   logic [WIDTH-1:0]       in_data;
   logic                   in_valid;
   logic                   in_ready;
   logic [SHIFT_WIDTH-1:0] fld_len;
   logic                   fld_ready;
   logic                   fld_valid;
   logic [WIDTH-1:0]       fld_data;
   logic [SHIFT_WIDTH+1:0] level;

   modport master (
      output in_data, in_valid, fld_len, fld_ready,
      input  in_ready, fld_valid, fld_data, level
   );

   modport slave (
      input  in_data, in_valid, fld_len, fld_ready,
      output in_ready, fld_valid, fld_data, level
   );

endinterface

// File: rtl/bit_field_extractor_shifter.sv
// Zero-fill logical barrel shifter, one mux stage per bit of the shift amount.
// The direction input selects left (1) or right (0) shifting.
module logic_shifter_2w
   import bfx_pkg::*;
#(
   parameter int DW = BUF_WIDTH,
   parameter int AW = $clog2(DW)
) (
   input  logic [DW-1:0] din,
   input  logic [AW-1:0] amt,
   input  logic          dir_left,
   output logic [DW-1:0] dout
);

   logic [DW-1:0] stage [0:AW];

   assign stage[0] = din;

   for (genvar i = 0; i < AW; i++) begin : g_stage
      assign stage[i+1] = !amt[i]  ? stage[i] :
                          dir_left ? (stage[i] << (1 << i)) :
                                     (stage[i] >> (1 << i));
   end

   assign dout = stage[AW];

endmodule

// File: rtl/bit_field_extractor.sv
// Streaming LSB-first bit unpacker: WIDTH-bit words in, 1..WIDTH-bit fields out.
// Define BIT_FIELD_EXTRACTOR_SIGN_EXT_EN to add the fld_signed port for sign-extended fields.
module bit_field_extractor
   import bfx_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int SHIFT_WIDTH = $clog2(WIDTH)
) (
   input  logic clk,
   input  logic rst,
   input  logic flush,
`ifdef BIT_FIELD_EXTRACTOR_SIGN_EXT_EN
   input  logic fld_signed,
`endif
   bit_field_extractor_if.slave bus
);

   localparam int BW = 2 * WIDTH;
   localparam int AW = SHIFT_WIDTH + 1;
   localparam int CW = SHIFT_WIDTH + 2;
   localparam logic [CW-1:0] W_CNT = CW'(WIDTH);

   logic [BW-1:0]    buf_q, buf_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [CW-1:0]    len;
   logic             take, push;
   logic [AW-1:0]    lamt;
   logic [BW-1:0]    rsh, lsh;
   logic [WIDTH-1:0] mask, field;

   assign len = CW'(len_decode(32'(bus.fld_len), WIDTH));

   assign bus.in_ready  = (cnt_q <= W_CNT);
   assign bus.fld_valid = (cnt_q >= len);
   assign bus.level     = cnt_q;

   assign take = bus.fld_valid & bus.fld_ready;
   assign push = bus.in_valid & bus.in_ready;

   // On a simultaneous take the new word lands just above what survives the take.
   assign lamt = take ? AW'(cnt_q - len) : AW'(cnt_q);

   logic_shifter_2w #(.DW(BW), .AW(AW)) u_rshift (
      .din      (buf_q),
      .amt      (AW'(len)),
      .dir_left (1'b0),
      .dout     (rsh)
   );

   logic_shifter_2w #(.DW(BW), .AW(AW)) u_lshift (
      .din      ({{WIDTH{1'b0}}, bus.in_data}),
      .amt      (lamt),
      .dir_left (1'b1),
      .dout     (lsh)
   );

   assign mask  = ~({WIDTH{1'b1}} << len);
   assign field = buf_q[WIDTH-1:0] & mask;

`ifdef BIT_FIELD_EXTRACTOR_SIGN_EXT_EN
   logic [SHIFT_WIDTH-1:0] msb_idx;
   assign msb_idx      = SHIFT_WIDTH'(len - CW'(1));
   assign bus.fld_data = (fld_signed && field[msb_idx]) ? (field | ~mask) : field;
`else
   assign bus.fld_data = field;
`endif

   always_comb begin
      buf_d = buf_q;
      cnt_d = cnt_q;
      if (flush) begin
         buf_d = '0;
         cnt_d = '0;
      end else begin
         case ({push, take})
            2'b01: begin
               buf_d = rsh;
               cnt_d = cnt_q - len;
            end
            2'b10: begin
               buf_d = buf_q | lsh;
               cnt_d = cnt_q + W_CNT;
            end
            2'b11: begin
               buf_d = rsh | lsh;
               cnt_d = cnt_q - len + W_CNT;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_q <= '0;
         cnt_q <= '0;
      end else begin
         buf_q <= buf_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: tb/tb_bit_field_extractor.sv
// Scoreboard bench for bit_field_extractor at WIDTH=8, modelled as a queue of buffered bits.
module tb_bit_field_extractor;

   localparam int W = 8;

   logic clk   = 1'b0;
   logic rst   = 1'b1;
   logic flush = 1'b0;
`ifdef BIT_FIELD_EXTRACTOR_SIGN_EXT_EN
   logic fld_signed = 1'b0;
`endif

   bit_field_extractor_if #(.WIDTH(W)) bus ();

   bit_field_extractor #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
`ifdef BIT_FIELD_EXTRACTOR_SIGN_EXT_EN
      .fld_signed (fld_signed),
`endif
      .bus        (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int           level;
      bit           in_ready;
      bit           fld_valid;
      logic [W-1:0] data;
   } status_t;

   status_t      status_q[$];
   logic [W-1:0] field_q[$];
   bit           model_bits[$];
   int           checks = 0;
   int           errors = 0;
   status_t      mon_s;

   // Reference field: first len buffered bits, missing bits read as zero, then extended.
   function automatic logic [W-1:0] model_field(input int len, input bit sgn);
      logic [W-1:0] v;
      for (int i = 0; i < W; i++) begin
         if (i < len) v[i] = (i < model_bits.size()) ? model_bits[i] : 1'b0;
         else         v[i] = sgn ? v[len-1] : 1'b0;
      end
      return v;
   endfunction

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] required);
      checks++;
      if (actual !== required) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, actual, required, $time);
      end
   endtask

   // Drive one cycle of inputs, record what the bench expects to see, then advance the model.
   task automatic apply_stimulus(input bit iv, input logic [W-1:0] d, input int len,
                                 input bit rdy, input bit fl, input bit rs, input bit sgn);
      status_t s;
      bit      take;
      bit      se;
      @(posedge clk);
      #1;
      rst           = rs;
      flush         = fl;
      bus.in_valid  = iv;
      bus.in_data   = d;
      bus.fld_len   = 3'(len % W);
      bus.fld_ready = rdy;
`ifdef BIT_FIELD_EXTRACTOR_SIGN_EXT_EN
      fld_signed = sgn;
      se         = sgn;
`else
      se = 1'b0;
`endif
      if (rs) model_bits.delete();
      s.level     = model_bits.size();
      s.in_ready  = (model_bits.size() <= W);
      s.fld_valid = (model_bits.size() >= len);
      s.data      = model_field(len, se);
      status_q.push_back(s);
      take = s.fld_valid && rdy;
      if (take) field_q.push_back(s.data);
      if (!rs) begin
         if (fl) begin
            model_bits.delete();
         end else begin
            if (take) repeat (len) void'(model_bits.pop_front());
            if (iv && s.in_ready) for (int i = 0; i < W; i++) model_bits.push_back(d[i]);
         end
      end
   endtask

   always @(negedge clk) begin
      if (status_q.size() > 0) begin
         mon_s = status_q.pop_front();
         check_output("level",     32'(bus.level),     32'(mon_s.level));
         check_output("in_ready",  32'(bus.in_ready),  32'(mon_s.in_ready));
         check_output("fld_valid", 32'(bus.fld_valid), 32'(mon_s.fld_valid));
         check_output("fld_data",  32'(bus.fld_data),  32'(mon_s.data));
      end
      if (bus.fld_valid === 1'b1 && bus.fld_ready === 1'b1 && rst === 1'b0) begin
         if (field_q.size() == 0) check_output("unexpected_take", 32'd1, 32'd0);
         else                     check_output("field", 32'(bus.fld_data), 32'(field_q.pop_front()));
      end
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.fld_len   = '0;
      bus.fld_ready = 1'b0;

      apply_stimulus(0, 8'h00, 8, 0, 0, 1, 0);
      apply_stimulus(0, 8'h00, 8, 0, 0, 1, 0);

      // Two words, then fields of 3,5,4,4 bits
      apply_stimulus(1, 8'hA5, 8, 0, 0, 0, 0);
      apply_stimulus(1, 8'h3C, 8, 0, 0, 0, 0);
      apply_stimulus(0, 8'h00, 3, 1, 0, 0, 0);
      apply_stimulus(0, 8'h00, 5, 1, 0, 0, 0);
      apply_stimulus(0, 8'h00, 4, 1, 0, 0, 0);
      apply_stimulus(0, 8'h00, 4, 1, 0, 0, 0);
      apply_stimulus(0, 8'h00, 1, 0, 0, 0, 0);

      // Fill to the full boundary, refuse a third word, then make room
      apply_stimulus(1, 8'h11, 8, 0, 0, 0, 0);
      apply_stimulus(1, 8'h22, 8, 0, 0, 0, 0);
      apply_stimulus(1, 8'h33, 8, 0, 0, 0, 0);
      apply_stimulus(0, 8'h00, 8, 1, 0, 0, 0);
      apply_stimulus(1, 8'h44, 8, 0, 0, 0, 0);
      apply_stimulus(0, 8'h00, 8, 1, 0, 0, 0);
      apply_stimulus(0, 8'h00, 8, 1, 0, 0, 0);

      // Partial bits retained below the requested length
      apply_stimulus(1, 8'h0F, 8, 0, 0, 0, 0);
      apply_stimulus(0, 8'h00, 4, 1, 0, 0, 0);
      apply_stimulus(1, 8'hFF, 5, 1, 0, 0, 0);
      apply_stimulus(0, 8'h00, 5, 1, 0, 0, 0);
      apply_stimulus(0, 8'h00, 7, 1, 0, 0, 0);

      // Simultaneous push and take, then full-word fields via fld_len=0
      apply_stimulus(1, 8'h5A, 8, 0, 0, 0, 0);
      apply_stimulus(0, 8'h00, 2, 1, 0, 0, 0);
      apply_stimulus(1, 8'hC3, 6, 1, 0, 0, 0);
      apply_stimulus(0, 8'h00, 8, 1, 0, 0, 0);
      apply_stimulus(1, 8'h96, 8, 0, 0, 0, 0);
      apply_stimulus(0, 8'h00, 8, 1, 0, 0, 0);

      // Flush at level 11 with a word offered
      apply_stimulus(1, 8'h12, 8, 0, 0, 0, 0);
      apply_stimulus(1, 8'h34, 8, 0, 0, 0, 0);
      apply_stimulus(0, 8'h00, 5, 1, 0, 0, 0);
      apply_stimulus(1, 8'h77, 8, 0, 1, 0, 0);
      apply_stimulus(0, 8'h00, 8, 0, 0, 0, 0);

      // Reset in the middle of a stream
      apply_stimulus(1, 8'hAB, 8, 0, 0, 0, 0);
      apply_stimulus(1, 8'hCD, 3, 1, 0, 0, 0);
      apply_stimulus(1, 8'hEF, 3, 1, 0, 1, 0);
      apply_stimulus(0, 8'h00, 8, 0, 0, 0, 0);

      // Signed and unsigned view of a 3-bit field 0b101
      apply_stimulus(1, 8'h05, 8, 0, 0, 0, 0);
      apply_stimulus(0, 8'h00, 3, 0, 0, 0, 1);
      apply_stimulus(0, 8'h00, 3, 1, 0, 0, 1);
      apply_stimulus(1, 8'h05, 5, 1, 0, 0, 0);
      apply_stimulus(0, 8'h00, 3, 1, 0, 0, 0);
      apply_stimulus(0, 8'h00, 5, 1, 0, 0, 1);

      repeat (3000) begin
         apply_stimulus($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(1, W),
                        $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0,
                        $urandom_range(0, 255) == 0, 1'($urandom_range(0, 1)));
      end

      apply_stimulus(0, 8'h00, 8, 0, 0, 0, 0);
      apply_stimulus(0, 8'h00, 8, 0, 0, 0, 0);
      @(negedge clk);
      #1;
      check_output("leftover_fields", 32'(field_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
